// File: rtl/insn_buffer_aligner.sv
// Halfword instruction buffer between fetch and decode: stores fetch words as
// halfword entries and presents one aligned 16-bit or 32-bit instruction per cycle.
module insn_buffer_aligner #(
  parameter int ENTRY_COUNT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [31:0]                  push_pc,
  input  logic                         push_fault,
  input  logic [31:0]                  push_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_insn,
  output logic                         out_compressed,
  output logic                         out_fault,
  output logic [$clog2(ENTRY_COUNT):0] entry_count
);

  localparam int IW = $clog2(ENTRY_COUNT);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] READY_MAX = PW'(ENTRY_COUNT - 2);
  localparam logic [PW:0]   COUNT_MAX = (PW + 1)'(ENTRY_COUNT);

  typedef struct packed {
    logic [31:0] pc;
    logic        fault;
    logic [15:0] insn;
  } entry_t;

  entry_t        mem [ENTRY_COUNT];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] count;
  logic [PW-1:0] rd_ptr_1;
  logic [PW-1:0] wr_ptr_1;
  entry_t        h0;
  entry_t        h1;
  logic          h0_short;
  logic          push_fire;
  logic          pop_fire;
  logic [PW-1:0] push_n;
  logic [PW-1:0] pop_n;
  logic [PW-1:0] push_amt;
  logic [PW-1:0] pop_amt;
  logic [PW:0]   nxt_count;

  assign count    = wr_ptr - rd_ptr;
  assign rd_ptr_1 = rd_ptr + PW'(1);
  assign wr_ptr_1 = wr_ptr + PW'(1);

  // H1 index wraps naturally through the low pointer bits, so no bubble at the seam
  assign h0 = mem[rd_ptr[IW-1:0]];
  assign h1 = mem[rd_ptr_1[IW-1:0]];

  // A faulted halfword is delivered alone, like a compressed instruction
  assign h0_short   = h0.fault | (h0.insn[1:0] != 2'b11);

  assign push_ready = (count <= READY_MAX);
  assign out_valid  = !flush & ((count >= PW'(2)) | ((count == PW'(1)) & h0_short));
  assign push_fire  = push_valid & push_ready & !flush;
  assign pop_fire   = out_valid & out_ready;

  assign push_n   = push_pc[1] ? PW'(1) : PW'(2);
  assign pop_n    = h0_short ? PW'(1) : PW'(2);
  assign push_amt = push_fire ? push_n : '0;
  assign pop_amt  = pop_fire ? pop_n : '0;

  assign nxt_count   = {1'b0, count} + {1'b0, push_amt} - {1'b0, pop_amt};
  assign entry_count = count;

  always_comb begin
    out_pc         = 32'h0;
    out_insn       = 32'h0;
    out_compressed = 1'b0;
    out_fault      = 1'b0;
    if (out_valid) begin
      out_pc = h0.pc;
      if (h0.fault) begin
        out_compressed = 1'b1;
        out_fault      = 1'b1;
      end else if (h0_short) begin
        out_insn       = {16'h0, h0.insn};
        out_compressed = 1'b1;
      end else begin
        out_insn  = {h1.insn, h0.insn};
        out_fault = h1.fault;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_amt;
      rd_ptr <= rd_ptr + pop_amt;
    end
  end

  // Storage is deliberately not reset; validity lives entirely in the pointers
  always_ff @(posedge clk) begin
    if (push_fire) begin
      if (push_pc[1]) begin
        mem[wr_ptr[IW-1:0]] <= {push_pc, push_fault, push_data[31:16]};
      end else begin
        mem[wr_ptr[IW-1:0]]   <= {push_pc, push_fault, push_data[15:0]};
        mem[wr_ptr_1[IW-1:0]] <= {push_pc + 32'd2, push_fault, push_data[31:16]};
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    flush || (nxt_count <= COUNT_MAX));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !pop_fire || (pop_n <= count));

endmodule
